irq_controller: RTL and testbench

//  Platform interrupt aggregator downstream of the peripheral wrappers (timer, UART, ...).

---
 rtl/irq_controller.sv | 153 +++++++++++++++
 tb/tb_irq_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt aggregator: latches source lines into pending bits, masks them with ENABLE and raises irq.
// Optional IRQC_SYNC_EN adds a synchronizer stage in front of the source sample flops.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module irq_controller #(
   parameter int N_SRC     = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [ADDR_BITS-1:0]             addr,
   input  logic                             w_rb,
   input  logic [$clog2(`BUS_ACC_CNT)-1:0]  acc,
   input  logic [`BUS_WIDTH-1:0]            wdata,
   output logic [`BUS_WIDTH-1:0]            rdata,
   input  logic                             req,
   output logic                             resp,
   output logic                             fault,
   input  logic [N_SRC-1:0]                 src,
   output logic                             irq
);

   localparam int BW = `BUS_WIDTH;
   localparam int AW = $clog2(`BUS_ACC_CNT);

   logic [N_SRC-1:0] pending_r, enable_r, edge_sel_r, src_s_r, src_p_r;
   logic [BW-1:0]    rdata_r;
   logic             resp_r, fault_r, irq_r;

   logic [N_SRC-1:0] src_in_s, active_s, claim_hot_s, clear_s, rise_s;
   logic [N_SRC-1:0] pending_nxt_s, enable_nxt_s, edge_nxt_s;
   logic [BW-1:0]    claim_code_s, rdata_nxt_s;
   logic [1:0]       reg_sel_s;
   logic             acc_ok_s, wr_s, rd_s;
   logic             unused_s;

   // Lowest set bit i yields i+1; no bit set yields 0.
   function automatic logic [BW-1:0] claim_code(input logic [N_SRC-1:0] act);
      logic [BW-1:0] code;
      code = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            code = BW'(i + 1);
         end else begin
            code = code;
         end
      end
      return code;
   endfunction

`ifdef IRQC_SYNC_EN
   logic [N_SRC-1:0] src_meta_r;

   // First synchronizer stage; src_s_r acts as the second.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         src_meta_r <= '0;
      end else begin
         src_meta_r <= src;
      end
   end
   assign src_in_s = src_meta_r;
`else
   assign src_in_s = src;
`endif

   assign unused_s = ^{wdata, addr};

   // Bus decode, claim selection and next-state of the register file.
   always_comb begin
      acc_ok_s     = (acc == AW'(2)) && (addr[1:0] == 2'b00);
      reg_sel_s    = addr[3:2];
      wr_s         = req & acc_ok_s & w_rb;
      rd_s         = req & acc_ok_s & ~w_rb;
      active_s     = pending_r & enable_r;
      claim_hot_s  = active_s & (~active_s + N_SRC'(1));
      claim_code_s = claim_code(active_s);
      rise_s       = src_s_r & ~src_p_r;

      if (wr_s && (reg_sel_s == 2'd0)) begin
         clear_s = wdata[N_SRC-1:0];
      end else if (rd_s && (reg_sel_s == 2'd2)) begin
         clear_s = claim_hot_s;
      end else begin
         clear_s = '0;
      end

      // Edge bits: a new rise beats any clear; level bits track the sampled line.
      pending_nxt_s = (edge_sel_r & ((pending_r & ~clear_s) | rise_s))
                    | (~edge_sel_r & src_s_r);

      if (wr_s && (reg_sel_s == 2'd1)) begin
         enable_nxt_s = wdata[N_SRC-1:0];
      end else begin
         enable_nxt_s = enable_r;
      end

      if (wr_s && (reg_sel_s == 2'd3)) begin
         edge_nxt_s = wdata[N_SRC-1:0];
      end else begin
         edge_nxt_s = edge_sel_r;
      end

      if (rd_s) begin
         case (reg_sel_s)
            2'd0:    rdata_nxt_s = BW'(pending_r);
            2'd1:    rdata_nxt_s = BW'(enable_r);
            2'd2:    rdata_nxt_s = claim_code_s;
            2'd3:    rdata_nxt_s = BW'(edge_sel_r);
            default: rdata_nxt_s = '0;
         endcase
      end else begin
         rdata_nxt_s = '0;
      end
   end

   // Register file, source sampling and bus response flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         src_s_r    <= '0;
         src_p_r    <= '0;
         pending_r  <= '0;
         enable_r   <= '0;
         edge_sel_r <= '0;
         rdata_r    <= '0;
         resp_r     <= 1'b0;
         fault_r    <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         src_s_r    <= src_in_s;
         src_p_r    <= src_s_r;
         pending_r  <= pending_nxt_s;
         enable_r   <= enable_nxt_s;
         edge_sel_r <= edge_nxt_s;
         rdata_r    <= rdata_nxt_s;
         resp_r     <= req;
         fault_r    <= req & ~acc_ok_s;
         // Same value as |(pending_r & enable_r) but straight from a flop.
         irq_r      <= |(pending_nxt_s & enable_nxt_s);
      end
   end

   assign rdata = rdata_r;
   assign resp  = resp_r;
   assign fault = fault_r;
   assign irq   = irq_r;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed table, corner sequences and random traffic
// compared against a per-bit behavioural model.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module tb_irq_controller;

   localparam int N = 8;
`ifdef IRQC_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif
   localparam int LAT = D + 1;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  addr;
   logic        w_rb;
   logic [1:0]  acc;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        req;
   logic        resp;
   logic        fault;
   logic [N-1:0] src;
   logic        irq;

   irq_controller #(.N_SRC(N), .ADDR_BITS(4)) dut (
      .clk(clk), .rstn(rstn), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
      .rdata(rdata), .req(req), .resp(resp), .fault(fault), .src(src), .irq(irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] m_pend, m_en, m_edge;
   logic [N-1:0] hist [0:3];
   logic         m_irq;
   logic [N-1:0] cur_src;
   logic [31:0]  last_rdata;
   logic         last_fault;

   typedef struct {
      bit          w;
      logic [3:0]  a;
      logic [1:0]  ac;
      logic [31:0] wd;
      logic [31:0] er;
      bit          ef;
   } vec_t;
   vec_t tbl [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_edge = '0; m_irq = 1'b0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
   endtask

   // Applies the register rules to one clock edge, using the state held before that edge.
   task automatic model_step(input bit rq, input bit w, input logic [3:0] a, input logic [1:0] ac,
                             input logic [31:0] wd, input logic [N-1:0] s,
                             output logic [31:0] er, output bit ef);
      logic [N-1:0] ss, sp, np, ne, ned;
      int ci;
      bit ok;
      ss = hist[D-1];
      sp = hist[D];
      ci = -1;
      for (int i = 0; i < N; i++) if (ci < 0 && m_pend[i] && m_en[i]) ci = i;
      er = 32'h0;
      ef = rq && ((ac != 2'd2) || (a[1:0] != 2'd0));
      ok = rq && !ef;
      ne = m_en;
      ned = m_edge;
      if (ok && !w) begin
         case (a[3:2])
            2'd0: er = 32'(m_pend);
            2'd1: er = 32'(m_en);
            2'd2: er = (ci < 0) ? 32'h0 : 32'(ci + 1);
            default: er = 32'(m_edge);
         endcase
      end
      if (ok && w && a[3:2] == 2'd1) ne = wd[N-1:0];
      if (ok && w && a[3:2] == 2'd3) ned = wd[N-1:0];
      for (int i = 0; i < N; i++) begin
         if (m_edge[i]) begin
            if (ss[i] && !sp[i]) np[i] = 1'b1;
            else if (ok && w && a[3:2] == 2'd0 && wd[i]) np[i] = 1'b0;
            else if (ok && !w && a[3:2] == 2'd2 && ci == i) np[i] = 1'b0;
            else np[i] = m_pend[i];
         end else begin
            np[i] = ss[i];
         end
      end
      m_pend = np;
      m_en = ne;
      m_edge = ned;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      m_irq = |(m_pend & m_en);
   endtask

   // One clock: drive at the falling edge, check at the next falling edge.
   task automatic step(input bit rq, input bit w, input logic [3:0] a, input logic [1:0] ac,
                       input logic [31:0] wd);
      logic [31:0] er;
      bit ef;
      req = rq; w_rb = w; addr = a; acc = ac; wdata = wd; src = cur_src;
      model_step(rq, w, a, ac, wd, cur_src, er, ef);
      @(posedge clk);
      @(negedge clk);
      chk("resp", 32'(resp), 32'(rq));
      if (rq) begin
         chk("rdata", rdata, er);
         chk("fault", 32'(fault), 32'(ef));
      end
      chk("irq", 32'(irq), 32'(m_irq));
      last_rdata = rdata;
      last_fault = fault;
      req = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      step(1'b1, 1'b0, a, 2'd2, 32'h0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      step(1'b1, 1'b1, a, 2'd2, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 2'd2, 32'h0);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 4'h0, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[1]  = '{1'b0, 4'h4, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[2]  = '{1'b0, 4'h8, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[3]  = '{1'b0, 4'hC, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[4]  = '{1'b1, 4'h4, 2'd2, 32'hA5,       32'h0,  1'b0};
      tbl[5]  = '{1'b0, 4'h4, 2'd2, 32'h0,        32'hA5, 1'b0};
      tbl[6]  = '{1'b0, 4'h4, 2'd0, 32'h0,        32'h0,  1'b1};
      tbl[7]  = '{1'b0, 4'h2, 2'd2, 32'h0,        32'h0,  1'b1};
      tbl[8]  = '{1'b1, 4'h4, 2'd1, 32'hFF,       32'h0,  1'b1};
      tbl[9]  = '{1'b0, 4'h4, 2'd2, 32'h0,        32'hA5, 1'b0};
      tbl[10] = '{1'b1, 4'h4, 2'd2, 32'hFFFFFF00, 32'h0,  1'b0};
      tbl[11] = '{1'b0, 4'h4, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[12] = '{1'b1, 4'hC, 2'd2, 32'h1FF,      32'h0,  1'b0};
      tbl[13] = '{1'b0, 4'hC, 2'd2, 32'h0,        32'hFF, 1'b0};
      tbl[14] = '{1'b1, 4'h8, 2'd2, 32'h1,        32'h0,  1'b0};
      tbl[15] = '{1'b0, 4'h0, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[16] = '{1'b1, 4'hC, 2'd2, 32'h0,        32'h0,  1'b0};
      tbl[17] = '{1'b0, 4'hC, 2'd2, 32'h0,        32'h0,  1'b0};

      rstn = 1'b0; req = 1'b0; w_rb = 1'b0; addr = 4'h0; acc = 2'd2; wdata = 32'h0;
      cur_src = '0; src = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_resp", 32'(resp), 32'h0);
      chk("reset_irq", 32'(irq), 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      rstn = 1'b1;

      // Register access, faults and reserved-bit behaviour
      for (int v = 0; v < 18; v++) begin
         step(1'b1, tbl[v].w, tbl[v].a, tbl[v].ac, tbl[v].wd);
         chk($sformatf("tbl%0d_rdata", v), last_rdata, tbl[v].er);
         chk($sformatf("tbl%0d_fault", v), 32'(last_fault), 32'(tbl[v].ef));
      end

      // Edge pulse on src[0], then CLAIM
      wr(4'hC, 32'h01);
      wr(4'h4, 32'h01);
      cur_src = 8'h01;
      idle(1);
      cur_src = 8'h00;
      idle(LAT - 2);
      chk("edge_irq_early", 32'(irq), 32'h0);
      idle(1);
      chk("edge_irq_lat", 32'(irq), 32'h1);
      rd(4'h0);
      chk("edge_pending", last_rdata, 32'h1);
      rd(4'h8);
      chk("edge_claim", last_rdata, 32'h1);
      rd(4'h0);
      chk("edge_pending_clr", last_rdata, 32'h0);
      chk("edge_irq_clr", 32'(irq), 32'h0);

      // Level source src[3]
      wr(4'hC, 32'h00);
      wr(4'h4, 32'h08);
      cur_src = 8'h08;
      idle(LAT);
      rd(4'h8);
      chk("lvl_claim1", last_rdata, 32'h4);
      rd(4'h8);
      chk("lvl_claim2", last_rdata, 32'h4);
      wr(4'h0, 32'h08);
      rd(4'h0);
      chk("lvl_w1c_ignored", last_rdata, 32'h8);
      cur_src = 8'h00;
      idle(1);
      idle(LAT - 2);
      chk("lvl_irq_hold", 32'(irq), 32'h1);
      idle(1);
      chk("lvl_irq_drop", 32'(irq), 32'h0);

      // Two edge sources, claimed in priority order
      wr(4'hC, 32'h22);
      wr(4'h4, 32'h22);
      cur_src = 8'h22;
      idle(1);
      cur_src = 8'h00;
      idle(LAT);
      rd(4'h8);
      chk("prio_claim1", last_rdata, 32'h2);
      rd(4'h8);
      chk("prio_claim2", last_rdata, 32'h6);
      rd(4'h8);
      chk("prio_claim3", last_rdata, 32'h0);
      chk("prio_irq", 32'(irq), 32'h0);

      // Rising edge on src[2] coincides with a W1C of that bit
      wr(4'hC, 32'h04);
      wr(4'h4, 32'h04);
      cur_src = 8'h04;
      idle(LAT - 1);
      wr(4'h0, 32'h04);
      rd(4'h0);
      chk("set_beats_w1c", last_rdata, 32'h4);

      // Reset during an outstanding request
      cur_src = 8'h00;
      src = 8'h00;
      req = 1'b1; w_rb = 1'b0; addr = 4'h0; acc = 2'd2;
      #2 rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_resp", 32'(resp), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      req = 1'b0;
      rstn = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         rd(4'(k * 4));
         chk($sformatf("rst_reg%0d", k), last_rdata, 32'h0);
      end

      // Random traffic against the model
      for (int it = 0; it < 3000; it++) begin
         logic [3:0] a;
         logic [1:0] ac;
         cur_src = cur_src ^ (N'($urandom) & N'($urandom));
         a = {2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
         ac = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd2;
         if ($urandom_range(0, 2) != 0)
            step(1'b1, 1'($urandom), a, ac, $urandom);
         else
            idle(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
